// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8N1 UART receive engine with one-deep byte buffer and valid/ack handshake
module uart_receive (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clk_div,
    input  logic        rx,
    input  logic        rx_ack,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    logic        rx_m;
    logic        rx_s;
    logic        rx_d;
    logic [31:0] div_q;
    logic [31:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic [31:0] div_eff;
    logic [31:0] div_m1;
    logic [31:0] half_m1;
    logic        start_edge;

    // Divisors below 4 would leave no room to find mid-bit, so they clamp to 4.
    assign div_eff    = (clk_div < 32'd4) ? 32'd4 : clk_div;
    assign div_m1     = div_q - 32'd1;
    assign half_m1    = {1'b0, div_q[31:1]} - 32'd1;
    assign start_edge = rx_d & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_q     <= 32'd4;
            cnt       <= 32'd0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Acknowledge clears first; a flag set later in this block takes precedence.
            if (rx_ack) begin
                rx_valid  <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start_edge) begin
                        state <= START;
                        cnt   <= 32'd0;
                        div_q <= div_eff;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == half_m1) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            cnt   <= 32'd0;
                            idx   <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (cnt == div_m1) begin
                        shift[idx] <= rx_s;
                        cnt        <= 32'd0;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (cnt == div_m1) begin
                        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 32'd0;
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_ack) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 32'd0;
                    idx   <= 3'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
